life_sweep: RTL and testbench
=============================

LIFE_SWEEP -- requirements
Module: life_sweep

Interface
REQ-001 SHALL have parameter ROWS, default 5, meaning grid row count (>=3).
REQ-002 SHALL have parameter COLS, default 5, meaning grid column count (>=3).
REQ-003 SHALL have parameter WIDTH, default 12, meaning per-axis coordinate width; addresses are 2*WIDTH bits.
REQ-004 SHALL have parameter BIRTH_MASK, default 9'b000001000, meaning bit k set = dead cell with k live neighbours becomes live (B3).
REQ-005 SHALL have parameter SURVIVE_MASK, default 9'b000001100, meaning bit k set = live cell with k live neighbours stays live (S23).
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-008 SHALL have port start, input, 1, meaning a one-cycle request to compute one generation.
REQ-009 SHALL have port busy, output, 1, meaning a sweep is in progress.
REQ-010 SHALL have port done, output, 1, meaning a one-cycle pulse when a generation completes.
REQ-011 SHALL have port rden, output, 1, meaning a source RAM read strobe.
REQ-012 SHALL have port read_pos, output, 2*WIDTH, meaning the source read address.
REQ-013 SHALL have port prev_status, input, 1, meaning source RAM data, valid the cycle after rden.
REQ-014 SHALL have port wden, output, 1, meaning a destination RAM write strobe.
REQ-015 SHALL have port write_pos, output, 2*WIDTH, meaning the destination write address.
REQ-016 SHALL have port live, output, 1, meaning the destination write data.
REQ-017 SHALL have port gen_count, output, 16, meaning completed generations.

Function
REQ-018 SHALL address cell (r,c) as r*COLS+c, row-major, and sweep cells in address order 0..ROWS*COLS-1.
REQ-019 SHALL use FSM states IDLE -> READ -> DRAIN -> WRITE -> (READ for the next cell | DONE) -> IDLE.
REQ-020 SHALL leave IDLE only when start=1; start while busy=1 SHALL be ignored.
REQ-021 SHALL spend exactly 9 cycles in READ per cell, slot k=0..8 visiting centre, E, SE, S, SW, W, NW, N, NE.
REQ-022 SHALL capture prev_status for slot k in the cycle after slot k, using DRAIN for slot 8.
REQ-023 SHALL, in WRITE, assert wden for one cycle with write_pos = centre address and live = the rule result.
REQ-024 SHALL compute the rule result as n = count of 8 neighbours (0..8, 4-bit), next = centre ? SURVIVE_MASK[n] : BIRTH_MASK[n].
REQ-025 SHALL take a fixed 11 cycles per cell, so done is asserted exactly 11*ROWS*COLS+1 cycles after the accepted start.
REQ-026 SHALL, in DONE, pulse done for one cycle, increment gen_count (wrapping at 2^16-1 to 0), and return to IDLE with busy=0.
REQ-027 SHALL hold busy=1 from the cycle after the accepted start through the DONE cycle.
REQ-028 SHALL keep rden and wden mutually exclusive, with wden=0 outside WRITE.

Reset
REQ-029 SHALL, on rst=1, force the FSM to IDLE and set busy, done, rden, wden, live, read_pos, write_pos and gen_count to 0 on the next edge.
REQ-030 SHALL, on rst=1 mid-sweep, abort without any further wden pulse, and SHALL not resume the aborted sweep.

Configuration
REQ-031 SHALL, with LIFE_TORUS_EN defined, compute off-grid neighbours modulo ROWS/COLS (toroidal) and read them from RAM.
REQ-032 SHALL, without LIFE_TORUS_EN, hold rden=0 in slots whose neighbour is off-grid, treat those neighbours as dead, and keep the 11-cycle per-cell timing.

Structure
REQ-033 SHALL place the FSM state enum, neighbour slot order, and default B3/S23 masks in shared package life_pkg.
REQ-034 SHALL implement the neighbour count and mask lookup in a combinational sub-module life_rule.

Verification
REQ-035 SHALL cover this scenario: 5x5 blinker with row 2, cols 1-3 live, then start -> col 2, rows 1-3 live, all other cells 0, and done at cycle 276.
REQ-036 SHALL cover this scenario: 2x2 block at (1,1)-(2,2) -> identical output, and gen_count 0->1.
REQ-037 SHALL cover this scenario: cells (0,4), (4,0), (4,4) live -> (0,0) written 1 with LIFE_TORUS_EN and 0 without, and without the macro no rden for off-grid slots.
REQ-038 SHALL cover this scenario: start re-pulsed at cycle 50 of a sweep -> ignored, exactly 25 wden pulses, and one done.
REQ-039 SHALL cover this scenario: rst at cycle 100 -> busy=0 and wden=0 the next cycle, and a fresh start then completes in 276 cycles.
REQ-040 SHALL cover this scenario: BIRTH_MASK=9'b000000010, SURVIVE_MASK=0, with a single live cell at (2,2) -> its 8 neighbours 1 and (2,2) 0.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared FSM states, neighbour slot order and default B3/S23 masks for life_sweep.
package life_pkg;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;
  localparam logic [8:0] B3 = 9'b000001000;
  localparam logic [8:0] S23 = 9'b000001100;
  localparam logic [3:0] LAST_SLOT = 4'd8;
  // Slots 8..0 = NE,N,NW,W,SW,S,SE,E,centre; 2'b01 = +1, 2'b11 = -1, 2'b00 = 0
  localparam logic [17:0] SLOT_DR = {2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [17:0] SLOT_DC = {2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00};
  function automatic logic [1:0] slot_dr(input logic [3:0] k);
    return SLOT_DR[{k, 1'b0} +: 2];
  endfunction
  function automatic logic [1:0] slot_dc(input logic [3:0] k);
    return SLOT_DC[{k, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/life_rule.sv
// life_rule: counts live neighbours and looks up the birth/survive masks.
module life_rule import life_pkg::*; #(
  parameter logic [8:0] BIRTH_MASK = B3,
  parameter logic [8:0] SURVIVE_MASK = S23
) (
  input  logic       i_centre,
  input  logic [7:0] i_nbrs,
  output logic       o_next
);
  logic [3:0] w_n;
  always_comb begin
    w_n = '0;
    for (int i = 0; i < 8; i++) w_n = w_n + 4'(i_nbrs[i]);
    o_next = i_centre ? SURVIVE_MASK[w_n] : BIRTH_MASK[w_n];
  end
endmodule

// File: rtl/life_sweep.sv
// life_sweep: sweeps a ROWS x COLS grid one cell at a time, 11 cycles per cell.
// Define LIFE_TORUS_EN for toroidal wrap; otherwise off-grid neighbours are dead and not read.
module life_sweep import life_pkg::*; #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int WIDTH = 12,
  parameter logic [8:0] BIRTH_MASK = B3,
  parameter logic [8:0] SURVIVE_MASK = S23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rden,
  output logic [2*WIDTH-1:0] read_pos,
  input  logic               prev_status,
  output logic               wden,
  output logic [2*WIDTH-1:0] write_pos,
  output logic               live,
  output logic [15:0]        gen_count
);
  localparam int AW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] LR = WIDTH'(ROWS - 1);
  localparam logic [WIDTH-1:0] LC = WIDTH'(COLS - 1);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_row, r_col, w_nr, w_nc;
  logic [AW-1:0] r_cell;
  logic [3:0] r_slot, r_cap_k;
  logic r_cap_en, r_cap_rd, r_centre, w_rule, w_last;
  logic [7:0] r_nbrs;
  logic [15:0] r_gen;
  logic [1:0] w_dr, w_dc;

  assign w_dr = slot_dr(r_slot);
  assign w_dc = slot_dc(r_slot);
  assign w_nr = w_dr == 2'b01 ? (r_row == LR ? '0 : r_row + WIDTH'(1))
              : w_dr == 2'b11 ? (r_row == '0 ? LR : r_row - WIDTH'(1)) : r_row;
  assign w_nc = w_dc == 2'b01 ? (r_col == LC ? '0 : r_col + WIDTH'(1))
              : w_dc == 2'b11 ? (r_col == '0 ? LC : r_col - WIDTH'(1)) : r_col;
  assign w_last = r_row == LR && r_col == LC;

`ifdef LIFE_TORUS_EN
  assign rden = r_state == READ;
`else
  logic w_off;
  assign w_off = (w_dr == 2'b01 && r_row == LR) || (w_dr == 2'b11 && r_row == '0) ||
                 (w_dc == 2'b01 && r_col == LC) || (w_dc == 2'b11 && r_col == '0);
  assign rden = r_state == READ && !w_off;
`endif

  assign read_pos = rden ? AW'(w_nr) * AW'(COLS) + AW'(w_nc) : '0;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign wden = r_state == WRITE;
  assign write_pos = wden ? r_cell : '0;
  assign live = wden & w_rule;
  assign gen_count = r_gen;

  life_rule #(.BIRTH_MASK(BIRTH_MASK), .SURVIVE_MASK(SURVIVE_MASK)) u_rule (
    .i_centre(r_centre), .i_nbrs(r_nbrs), .o_next(w_rule)
  );

  always_comb begin
    w_next = r_state == IDLE  ? (start ? READ : IDLE)
           : r_state == READ  ? (r_slot == LAST_SLOT ? DRAIN : READ)
           : r_state == DRAIN ? WRITE
           : r_state == WRITE ? (w_last ? DONE : READ) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gen <= '0;
      r_cap_en <= 1'b0;
      r_cap_rd <= 1'b0;
      r_cap_k <= '0;
      r_slot <= '0;
      r_row <= '0;
      r_col <= '0;
      r_cell <= '0;
    end else begin
      r_state <= w_next;
      r_cap_en <= r_state == READ;
      r_cap_k <= r_slot;
      r_cap_rd <= rden;
      // Data for a slot arrives the cycle after its read; unread slots count as dead
      if (r_cap_en && r_cap_k == '0) r_centre <= r_cap_rd & prev_status;
      if (r_cap_en && r_cap_k != '0) r_nbrs[3'(r_cap_k - 4'd1)] <= r_cap_rd & prev_status;
      r_slot <= (r_state == READ && r_slot != LAST_SLOT) ? r_slot + 4'd1 : '0;
      if (r_state == IDLE) begin
        r_row <= '0;
        r_col <= '0;
        r_cell <= '0;
      end
      if (r_state == WRITE) begin
        r_col <= r_col == LC ? '0 : r_col + WIDTH'(1);
        r_row <= r_col == LC ? r_row + WIDTH'(1) : r_row;
        r_cell <= r_cell + AW'(1);
      end
      if (r_state == DONE) r_gen <= r_gen + 16'd1;
    end
  end
endmodule

// File: tb/tb_life_sweep.sv
// tb_life_sweep: directed scenarios against a whole-grid Life model, checked per write.
module tb_life_sweep;
  localparam int R = 5, C = 5, N = 25;
  logic clk = 0, rst = 1, start = 0, start2 = 0;
  logic prev_status = 0, prev2 = 0;
  logic busy, done, rden, wden, live, busy2, done2, rden2, wden2, live2;
  logic [23:0] read_pos, write_pos, rpos2, wpos2;
  logic [15:0] gen_count, gen2;
  logic [N-1:0] src = '0, exp_g = '0, src2 = '0, exp2 = '0;
  int vec = 0, errs = 0, wcount = 0, wcount2 = 0, nrd = 0, ndone = 0;

  always #5 clk = ~clk;

  life_sweep dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rden(rden),
    .read_pos(read_pos), .prev_status(prev_status), .wden(wden), .write_pos(write_pos),
    .live(live), .gen_count(gen_count)
  );
  life_sweep #(.BIRTH_MASK(9'b000000010), .SURVIVE_MASK(9'b000000000)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .rden(rden2),
    .read_pos(rpos2), .prev_status(prev2), .wden(wden2), .write_pos(wpos2),
    .live(live2), .gen_count(gen2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] step(input logic [N-1:0] g, input logic [8:0] b, input logic [8:0] s);
    logic [N-1:0] o;
    o = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) begin
              int rr, cc;
              rr = r + dr;
              cc = c + dc;
`ifdef LIFE_TORUS_EN
              rr = (rr + R) % R;
              cc = (cc + C) % C;
`endif
              if (rr >= 0 && rr < R && cc >= 0 && cc < C) n += int'(g[rr*C+cc]);
            end
        o[r*C+c] = g[r*C+c] ? s[n] : b[n];
      end
    return o;
  endfunction

  function automatic int reads();
    int t;
    t = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
`ifdef LIFE_TORUS_EN
            t++;
`else
            if (r + dr >= 0 && r + dr < R && c + dc >= 0 && c + dc < C) t++;
`endif
          end
    return t;
  endfunction

  // Source RAMs: unread cycles return 1 so a design that trusts unread data is caught
  always @(posedge clk) begin
    prev_status <= (rden && read_pos < N) ? src[read_pos[4:0]] : 1'b1;
    prev2 <= (rden2 && rpos2 < N) ? src2[rpos2[4:0]] : 1'b1;
  end

  always @(negedge clk) begin
    check("rden_wden_excl", {31'd0, rden & wden}, 0);
    if (rden) begin
      nrd++;
      check("read_pos_range", {31'd0, read_pos < N}, 1);
    end
    if (wden) begin
      check("write_pos", write_pos, wcount);
      check("live", live, wcount < N ? exp_g[wcount] : 1'bx);
      wcount++;
    end
    if (wden2) begin
      check("write_pos2", wpos2, wcount2);
      check("live2", live2, wcount2 < N ? exp2[wcount2] : 1'bx);
      wcount2++;
    end
    if (done) ndone++;
  end

  task automatic run(input int repulse, input bit go2, output int cyc);
    wcount = 0;
    wcount2 = 0;
    nrd = 0;
    @(negedge clk);
    start = 1;
    start2 = go2;
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 0;
      start2 = 0;
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (cyc == repulse) start = 1;
      if (done) break;
    end
    check("done_cycle", cyc, 276);
    if (go2) check("done2_with_done", done2, 1);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int cyc, nd0, saved;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rden", rden, 0);
    check("rst_wden", wden, 0);
    check("rst_live", live, 0);
    check("rst_read_pos", read_pos, 0);
    check("rst_write_pos", write_pos, 0);
    check("rst_gen_count", gen_count, 0);
    rst = 0;

    src = '0;
    src[6] = 1; src[7] = 1; src[11] = 1; src[12] = 1;
    exp_g = step(src, 9'b000001000, 9'b000001100);
    check("model_block", exp_g, src);
    run(0, 0, cyc);
    check("block_writes", wcount, 25);
    check("block_gen", gen_count, 1);
    check("block_reads", nrd, reads());

    src = '0;
    src[11] = 1; src[12] = 1; src[13] = 1;
    exp_g = step(src, 9'b000001000, 9'b000001100);
    check("model_blinker", exp_g, 25'b0000000100001000010000000);
    src2 = '0;
    src2[12] = 1;
    exp2 = step(src2, 9'b000000010, 9'b000000000);
    check("model_seeds", exp2, 25'b0000001110010100111000000);
    run(0, 1, cyc);
    check("blinker_writes", wcount, 25);
    check("blinker_gen", gen_count, 2);
    check("seeds_writes", wcount2, 25);
    check("seeds_gen", gen2, 1);

    src = '0;
    src[4] = 1; src[20] = 1; src[24] = 1;
    exp_g = step(src, 9'b000001000, 9'b000001100);
`ifdef LIFE_TORUS_EN
    check("model_corner", {31'd0, exp_g[0]}, 1);
    check("model_reads", reads(), 225);
`else
    check("model_corner", {31'd0, exp_g[0]}, 0);
    check("model_reads", reads(), 169);
`endif
    run(0, 0, cyc);
    check("corner_reads", nrd, reads());
    check("corner_gen", gen_count, 3);

    src = 25'h0B5_3C6A;
    exp_g = step(src, 9'b000001000, 9'b000001100);
    nd0 = ndone;
    run(50, 0, cyc);
    repeat (20) @(posedge clk);
    #1;
    check("repulse_writes", wcount, 25);
    check("repulse_dones", ndone - nd0, 1);
    check("repulse_gen", gen_count, 4);

    src = 25'h1C4_9A13;
    exp_g = step(src, 9'b000001000, 9'b000001100);
    wcount = 0;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_wden", wden, 0);
    check("abort_gen", gen_count, 0);
    rst = 0;
    saved = wcount;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_resume", wcount, saved);
    check("abort_idle", busy, 0);
    run(0, 0, cyc);
    check("fresh_writes", wcount, 25);
    check("fresh_gen", gen_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
